// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM states and the per-stage control record.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      HALT    = 2'd2
   } hz_state_e;

   localparam logic [31:0] NOP_IR = 32'h0000_0000;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
   localparam pipe_ctl_t CTL_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
   localparam pipe_ctl_t CTL_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
   localparam pipe_ctl_t CTL_JUMP  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (inc && (q_q != {CNT_W{1'b1}})) q_d = q_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Applies hazard requests to PC / IF/ID / ID/EX enables, tracks halt and branch
// bubbles, and keeps saturating performance counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use,
   input  logic             bubble_f,
   input  logic             bubble_j,
   input  logic             branch_taken,
   input  logic             halt,
   input  logic             go,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             bubble_f_new,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] br_cnt
);

   localparam int NCNT = 4;

   hz_state_e state_q, state_d;
   logic      bubble_f_new_q, bubble_f_new_d;
   logic      halted_q, halted_d;
   pipe_ctl_t ctl;
   logic      lu_inc, flush_inc, br_inc, cyc_inc;

   logic [NCNT-1:0]            cnt_inc;
   logic [NCNT-1:0][CNT_W-1:0] cnt_q;

   always_comb begin
      ctl       = CTL_RUN;
      state_d   = state_q;
      lu_inc    = 1'b0;
      flush_inc = 1'b0;
      br_inc    = 1'b0;
      cyc_inc   = (state_q != HALT);
      if (state_q == HALT) begin
         ctl = CTL_STALL;
         if (go) state_d = RUN;
      end else if (halt) begin
         ctl     = CTL_STALL;
         state_d = HALT;
      end else if (branch_taken) begin
         ctl       = CTL_FLUSH;
         state_d   = RUN;
         flush_inc = 1'b1;
      end else if (load_use) begin
         // Stall holds the current state, so a pending BR_WAIT resumes afterwards.
         ctl    = CTL_STALL;
         lu_inc = 1'b1;
      end else if (bubble_j) begin
         ctl       = CTL_JUMP;
         state_d   = RUN;
         flush_inc = 1'b1;
      end else if (bubble_f && state_q == RUN) begin
         ctl     = CTL_STALL;
         state_d = BR_WAIT;
         br_inc  = 1'b1;
      end else begin
         state_d = RUN;
      end
   end

   assign bubble_f_new_d = (state_q != HALT) & bubble_f & ~load_use & ~branch_taken & ~halt;
   assign halted_d       = (state_d == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         bubble_f_new_q <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         bubble_f_new_q <= bubble_f_new_d;
         halted_q       <= halted_d;
      end
   end

   assign cnt_inc = {br_inc, flush_inc, lu_inc, cyc_inc};

   for (genvar i = 0; i < NCNT; i++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (cnt_inc[i]),
         .q     (cnt_q[i])
      );
   end

   assign pc_en        = ctl.pc_en;
   assign ifid_en      = ctl.ifid_en;
   assign ifid_flush   = ctl.ifid_flush;
   assign idex_flush   = ctl.idex_flush;
   assign bubble_f_new = bubble_f_new_q;
   assign halted       = halted_q;
   assign cycle_cnt    = cnt_q[0];
   assign lu_cnt       = cnt_q[1];
   assign flush_cnt    = cnt_q[2];
   assign br_cnt       = cnt_q[3];

endmodule
